// File: rtl/keyword_verdict_gen.sv
// keyword_verdict_gen
//   Captures one AXI-Stream frame at a time into a beat buffer, scans the
//   valid bytes for KEYWORD, and raises allow_sig or deny_sig.  Once ack is
//   seen, the buffered frame is replayed on the master port.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   CAPTURE  | accepting beats into the buffer and scanning bytes
//   DISCARD  | buffer overflowed; dropping beats up to tlast
//   VERDICT  | allow_sig/deny_sig held high until ack is sampled
//   REPLAY   | streaming buffered beats out on m_axis
//
// Ports
//   clk, reset_n                 clock, async active-low reset
//   allow_sig, deny_sig, ack     verdict handshake towards the gate
//   s_axis_*                     frame input (64-bit data, 8-bit keep)
//   m_axis_*                     frame replay
//   frames_allowed/denied        accepted verdict counters, wrap at 2^16
module keyword_verdict_gen #(
    parameter int          BUF_DEPTH   = 256,
    parameter logic [63:0] KEYWORD     = 64'h0000746572636573,
    parameter int          KEYWORD_LEN = 6
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        allow_sig,
    output logic        deny_sig,
    input  logic        ack,
    input  logic [63:0] s_axis_tdata,
    input  logic [7:0]  s_axis_tkeep,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic [63:0] m_axis_tdata,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic [15:0] frames_allowed,
    output logic [15:0] frames_denied
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam int KL = KEYWORD_LEN;

    typedef enum logic [1:0] {ST_CAPTURE, ST_DISCARD, ST_VERDICT, ST_REPLAY} state_t;

    state_t         state;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [7:0]     hist [0:6];
    logic [2:0]     hist_cnt;
    logic           match;
    logic           bad;
    logic           loaded_last;

    // buffer word: {last_mark, tuser, tkeep, tdata}
    logic [73:0]    mem [BUF_DEPTH];
    logic [73:0]    wr_word;
    logic [73:0]    rd_word;
    logic           wr_en;

    logic           s_acc;
    logic           wr_full_beat;
    logic [3:0]     n_bytes;
    logic           hit;
    logic [7:0]     ext_b [0:14];
    logic [7:0]     hist_next [0:6];
    logic [2:0]     hcnt_next;
    logic           match_now;
    logic           bad_now;

    assign s_acc        = s_axis_tvalid && s_axis_tready;
    assign wr_full_beat = (wr_ptr == AW'(BUF_DEPTH - 1));
    assign wr_en        = (state == ST_CAPTURE) && s_acc;
    // A beat that fills the buffer without tlast closes the stored frame
    // and is flagged bad through tuser so the gate sees the truncation.
    assign wr_word      = {s_axis_tlast | wr_full_beat,
                           s_axis_tuser | (wr_full_beat & ~s_axis_tlast),
                           s_axis_tkeep, s_axis_tdata};
    assign rd_word      = mem[rd_ptr];
    assign match_now    = match | hit;
    assign bad_now      = bad | s_axis_tuser | (wr_full_beat & ~s_axis_tlast);

    // Byte window: ext_b[0..6] is history (index 6 newest), ext_b[7..14] the
    // current beat.  A keyword ending on beat byte j starts at 8+j-KL.
    always_comb begin
        int sum;
        logic ok;
        n_bytes = '0;
        for (int i = 0; i < 8; i++) n_bytes = n_bytes + {3'b000, s_axis_tkeep[i]};
        for (int i = 0; i < 7; i++) ext_b[i] = hist[i];
        for (int i = 0; i < 8; i++) ext_b[7+i] = s_axis_tdata[8*i +: 8];

        hit = 1'b0;
        for (int j = 0; j < 8; j++) begin
            ok = (j < int'(n_bytes)) && (j + int'(hist_cnt) >= KL - 1);
            for (int k = 0; k < KL; k++)
                if (ext_b[8 + j - KL + k] != KEYWORD[8*k +: 8]) ok = 1'b0;
            hit = hit | ok;
        end

        for (int i = 0; i < 7; i++) hist_next[i] = ext_b[i + int'(n_bytes)];
        sum = int'(hist_cnt) + int'(n_bytes);
        hcnt_next = (sum > KL - 1) ? 3'(KL - 1) : 3'(sum);
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_word;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_CAPTURE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            for (int i = 0; i < 7; i++) hist[i] <= '0;
            hist_cnt       <= '0;
            match          <= 1'b0;
            bad            <= 1'b0;
            loaded_last    <= 1'b0;
            allow_sig      <= 1'b0;
            deny_sig       <= 1'b0;
            s_axis_tready  <= 1'b0;
            m_axis_tdata   <= '0;
            m_axis_tkeep   <= '0;
            m_axis_tvalid  <= 1'b0;
            m_axis_tlast   <= 1'b0;
            m_axis_tuser   <= 1'b0;
            frames_allowed <= '0;
            frames_denied  <= '0;
        end else begin
            case (state)
                ST_CAPTURE: begin
                    s_axis_tready <= 1'b1;
                    if (s_acc) begin
                        wr_ptr   <= wr_ptr + 1'b1;
                        hist     <= hist_next;
                        hist_cnt <= hcnt_next;
                        match    <= match_now;
                        bad      <= bad_now;
                        if (s_axis_tlast) begin
                            state         <= ST_VERDICT;
                            s_axis_tready <= 1'b0;
                            deny_sig      <= match_now | bad_now;
                            allow_sig     <= ~(match_now | bad_now);
                        end else if (wr_full_beat) begin
                            state <= ST_DISCARD;
                        end
                    end
                end
                ST_DISCARD: begin
                    if (s_acc && s_axis_tlast) begin
                        state         <= ST_VERDICT;
                        s_axis_tready <= 1'b0;
                        deny_sig      <= 1'b1;
                    end
                end
                ST_VERDICT: begin
                    if (ack) begin
                        allow_sig   <= 1'b0;
                        deny_sig    <= 1'b0;
                        if (allow_sig) frames_allowed <= frames_allowed + 16'd1;
                        else           frames_denied  <= frames_denied + 16'd1;
                        state       <= ST_REPLAY;
                        rd_ptr      <= '0;
                        loaded_last <= 1'b0;
                    end
                end
                ST_REPLAY: begin
                    if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                        state         <= ST_CAPTURE;
                        wr_ptr        <= '0;
                        rd_ptr        <= '0;
                        hist_cnt      <= '0;
                        match         <= 1'b0;
                        bad           <= 1'b0;
                        loaded_last   <= 1'b0;
                        s_axis_tready <= 1'b1;
                        m_axis_tvalid <= 1'b0;
                        m_axis_tdata  <= '0;
                        m_axis_tkeep  <= '0;
                        m_axis_tlast  <= 1'b0;
                        m_axis_tuser  <= 1'b0;
                    end else if ((!m_axis_tvalid || m_axis_tready) && !loaded_last) begin
                        m_axis_tdata  <= rd_word[63:0];
                        m_axis_tkeep  <= rd_word[71:64];
                        m_axis_tuser  <= rd_word[72];
                        m_axis_tlast  <= rd_word[73];
                        m_axis_tvalid <= 1'b1;
                        loaded_last   <= rd_word[73];
                        rd_ptr        <= rd_ptr + 1'b1;
                    end else if (m_axis_tready) begin
                        m_axis_tvalid <= 1'b0;
                    end
                end
                default: state <= ST_CAPTURE;
            endcase
        end
    end

endmodule
